// File: rtl/mult_job_sequencer_pkg.sv
// Shared types and constants for the multiplier job sequencer:
// FSM state encoding, operand/result widths and parameter defaults.
package mult_seq_pkg;

    localparam int OP_W   = 8;    // operand width
    localparam int RES_W  = 16;   // full 8x8 product width
    localparam int JOBS_W = 8;    // completed-job counter width (wraps)
    localparam int CNT_W  = 16;   // shared LOAD/RUN cycle counter width

    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_START_CYCLES   = 2;
    localparam int DEF_TIMEOUT_CYCLES = 200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One queue entry holds the multiplicand in the upper byte and the
    // multiplier in the lower byte.
    function automatic logic [2*OP_W-1:0] pack_pair(input logic [OP_W-1:0] a,
                                                    input logic [OP_W-1:0] b);
        return {a, b};
    endfunction

endpackage

// File: rtl/mult_job_sequencer_if.sv
// Operand-in / result-out handshake bundle of the job sequencer.
// master = producer/consumer side, slave = sequencer side.
interface mult_job_sequencer_if;
    import mult_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_result;
    logic             out_timeout;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_timeout
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_timeout
    );

endinterface

// File: rtl/mult_op_fifo.sv
// Small operand-pair queue. Entries live in plain registers and the head
// is read combinationally so the sequencer can pop and use it in one cycle.
// Pointers carry one extra wrap bit to tell full from empty.
module mult_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign dout  = mem[rd_ptr_reg[AW-1:0]];

    // Storage: each entry captures din when the write pointer addresses it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                mem[gi] <= din;
            end
        end
    end

    // Pointer update; reset discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// Queues 8x8 operand pairs and feeds them one at a time to an external
// shift-add multiplier: hold it in reset with operands applied, release it,
// wait (bounded) for completion, then present the product until accepted.
// The multiplier stays in reset whenever no job is running.
module mult_job_sequencer
    import mult_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int START_CYCLES   = DEF_START_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    mult_job_sequencer_if.slave bus,
    output logic              busy,
    output logic [JOBS_W-1:0] jobs_done,
    output logic              mult_rst,
    output logic [OP_W-1:0]   mult_multiplicand,
    output logic [OP_W-1:0]   mult_multiplier,
    input  logic [RES_W-1:0]  mult_result,
    input  logic              mult_end_op
);

    state_t            state_reg,   state_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic [OP_W-1:0]   a_reg,       a_next;
    logic [OP_W-1:0]   b_reg,       b_next;
    logic [RES_W-1:0]  result_reg,  result_next;
    logic              timeout_reg, timeout_next;
    logic              valid_reg,   valid_next;
    logic              mult_rst_reg, mult_rst_next;
    logic [JOBS_W-1:0] jobs_reg,    jobs_next;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*OP_W-1:0] fifo_dout;

    assign bus.in_ready = !fifo_full;
    assign fifo_push    = bus.in_valid && !fifo_full;

    mult_op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*OP_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (pack_pair(bus.in_a, bus.in_b)),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and next-output logic. The single counter counts down the
    // LOAD reset window and counts up the RUN cycles for the timeout.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        result_next  = result_reg;
        timeout_next = timeout_reg;
        valid_next   = valid_reg;
        jobs_next    = jobs_reg;
        fifo_pop     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    a_next     = fifo_dout[2*OP_W-1:OP_W];
                    b_next     = fifo_dout[OP_W-1:0];
                    cnt_next   = CNT_W'(START_CYCLES - 1);
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RUN: begin
                if (mult_end_op) begin
                    result_next  = mult_result;
                    timeout_next = 1'b0;
                    valid_next   = 1'b1;
                    state_next   = DONE;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Multiplier never answered: report an empty result.
                    result_next  = '0;
                    timeout_next = 1'b1;
                    valid_next   = 1'b1;
                    state_next   = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    valid_next = 1'b0;
                    jobs_next  = jobs_reg + 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Registered so the multiplier reset is glitch-free; only RUN frees it.
        mult_rst_next = (state_next != RUN);
    end

    // State and output registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            result_reg   <= '0;
            timeout_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            mult_rst_reg <= 1'b1;
            jobs_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            result_reg   <= result_next;
            timeout_reg  <= timeout_next;
            valid_reg    <= valid_next;
            mult_rst_reg <= mult_rst_next;
            jobs_reg     <= jobs_next;
        end
    end

    assign bus.out_valid     = valid_reg;
    assign bus.out_result    = result_reg;
    assign bus.out_timeout   = timeout_reg;
    assign busy              = (state_reg != IDLE) || !fifo_empty;
    assign jobs_done         = jobs_reg;
    assign mult_rst          = mult_rst_reg;
    assign mult_multiplicand = a_reg;
    assign mult_multiplier   = b_reg;

endmodule
